// File: rtl/z80_bus_pkg.sv
// rtl/z80_bus_pkg.sv - shared types and constants for the z80 bus environment
// Purpose: access-kind and bus-request state encodings used by the bus model
//          and its wait generator, plus the value returned on an idle read bus.
package z80_bus_pkg;

  typedef enum logic [1:0] {
    ACC_FETCH = 2'd0,
    ACC_MRD   = 2'd1,
    ACC_MWR   = 2'd2,
    ACC_IO    = 2'd3
  } acc_kind_t;

  typedef enum logic [1:0] {
    BR_IDLE    = 2'd0,
    BR_REQ     = 2'd1,
    BR_GRANT   = 2'd2,
    BR_RELEASE = 2'd3
  } br_state_t;

  localparam logic [7:0] IO_UNMAPPED = 8'hFF;

  // Width of the wait-state counter; wait settings above 255 are truncated.
  localparam int WAIT_CW = 8;

endpackage

// File: rtl/z80_wait_gen.sv
// rtl/z80_wait_gen.sv - programmable wait-state generator driving nWAIT
// Purpose: loads a per-kind wait count when an access starts and holds nWAIT
//          low (registered) until the count drains or the strobes drop.
// Ports:
//   clk_i, rst_n_i  clock, asynchronous active-low reset
//   start_i         access-start pulse (one cycle)
//   kind_i          kind of the access starting this cycle
//   active_i        any access strobe currently active
//   nwait_o         registered wait request to the core (active low)
module z80_wait_gen
  import z80_bus_pkg::*;
#(
  parameter int WAIT_M1  = 0,
  parameter int WAIT_MEM = 0,
  parameter int WAIT_IO  = 0
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  input  logic      start_i,
  input  acc_kind_t kind_i,
  input  logic      active_i,
  output logic      nwait_o
);

  localparam logic [WAIT_CW-1:0] W_M1  = WAIT_CW'(WAIT_M1);
  localparam logic [WAIT_CW-1:0] W_MEM = WAIT_CW'(WAIT_MEM);
  localparam logic [WAIT_CW-1:0] W_IO  = WAIT_CW'(WAIT_IO);

  logic [WAIT_CW-1:0] cnt_q, cnt_d, load_val;
  logic               nwait_q, nwait_d;

  always_comb begin
    load_val = W_MEM;
    case (kind_i)
      ACC_FETCH: load_val = W_M1;
      ACC_IO:    load_val = W_IO;
      default:   load_val = W_MEM;
    endcase
  end

  // nWAIT tracks "count still non-zero after this edge", so a load of N
  // gives exactly N low cycles starting the cycle after the start edge.
  always_comb begin
    cnt_d   = cnt_q;
    nwait_d = 1'b1;
    if (start_i) begin
      cnt_d   = load_val;
      nwait_d = (load_val == '0);
    end else if (!active_i) begin
      cnt_d   = '0;
      nwait_d = 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d   = cnt_q - 1'b1;
      nwait_d = (cnt_q == WAIT_CW'(1));
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q   <= '0;
      nwait_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      nwait_q <= nwait_d;
    end
  end

  assign nwait_o = nwait_q;

endmodule

// File: rtl/z80_bus_model.sv
// rtl/z80_bus_model.sv - memory/IO/wait/bus-request environment for the z80 core
// Purpose: answers core bus cycles from a byte memory and a small I/O register
//          file, inserts wait states, generates BUSRQ handshakes and reports
//          one event per bus access. The bench may preload memory.
// Ports:
//   CLK, nRESET                       clock, asynchronous active-low reset
//   A, nMREQ, nIORQ, nRD, nWR, nM1,
//   nRFSH, nBUSAK, WRITE_D            core pins observed
//   READ_D, nWAIT, nBUSRQ             core pins driven
//   load_we, load_addr, load_data     memory preload port
//   ev_valid, ev_kind, ev_addr,
//   ev_data                           per-access event, valid the cycle after start
module z80_bus_model
  import z80_bus_pkg::*;
#(
  parameter int MEM_AW       = 16,
  parameter int IO_PORTS     = 4,
  parameter int WAIT_M1      = 0,
  parameter int WAIT_MEM     = 0,
  parameter int WAIT_IO      = 0,
  parameter int BUSRQ_PERIOD = 0,
  parameter int BUSRQ_HOLD   = 4
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic [15:0]       A,
  input  logic              nMREQ,
  input  logic              nIORQ,
  input  logic              nRD,
  input  logic              nWR,
  input  logic              nM1,
  input  logic              nRFSH,
  input  logic              nBUSAK,
  input  logic [7:0]        WRITE_D,
  output logic [7:0]        READ_D,
  output logic              nWAIT,
  output logic              nBUSRQ,
  input  logic              load_we,
  input  logic [MEM_AW-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              ev_valid,
  output logic [1:0]        ev_kind,
  output logic [15:0]       ev_addr,
  output logic [7:0]        ev_data
);

  localparam int IO_IW = (IO_PORTS > 1) ? $clog2(IO_PORTS) : 1;

  logic [7:0] mem [2**MEM_AW];
  logic [7:0] io_regs_q [IO_PORTS];

  logic [IO_IW-1:0] io_idx;
  logic             mrd_act, mwr_act, io_act, any_act;
  logic             mrd_q, mwr_q, io_q;
  logic             start_mrd, start_mwr, start_io, start_any;
  acc_kind_t        acc_kind;
  logic             acc_is_wr;

  logic             ev_valid_q;
  acc_kind_t        ev_kind_q;
  logic [15:0]      ev_addr_q;
  logic [7:0]       ev_data_q;

  br_state_t        br_state_q;
  logic [15:0]      br_cnt_q;
  logic             nbusrq_q;

  assign io_idx = IO_IW'({1'b0, A[7:0]} % 9'(IO_PORTS));

  // With nBUSAK low the core has floated its pins, so nothing is decoded.
  // Refresh cycles carry nMREQ low; nRFSH excludes them from memory decode.
  assign mrd_act = !nMREQ && !nRD && nRFSH && nBUSAK;
  assign mwr_act = !nMREQ && !nWR && nRFSH && nBUSAK;
  assign io_act  = !nIORQ && (!nRD || !nWR) && nBUSAK;
  assign any_act = mrd_act || mwr_act || io_act;

  // Starts are gated by nRESET so a strobe held through reset commits nothing.
  assign start_mrd = nRESET && mrd_act && !mrd_q;
  assign start_mwr = nRESET && mwr_act && !mwr_q;
  assign start_io  = nRESET && io_act  && !io_q;
  assign start_any = start_mrd || start_mwr || start_io;

  always_comb begin
    acc_kind  = nM1 ? ACC_MRD : ACC_FETCH;
    acc_is_wr = 1'b0;
    if (start_io) begin
      acc_kind  = ACC_IO;
      acc_is_wr = !nWR;
    end else if (start_mwr) begin
      acc_kind  = ACC_MWR;
      acc_is_wr = 1'b1;
    end
  end

  always_comb begin
    READ_D = IO_UNMAPPED;
    if (!nRESET) begin
      READ_D = IO_UNMAPPED;
    end else if (mrd_act) begin
      READ_D = mem[A[MEM_AW-1:0]];
    end else if (io_act && !nRD) begin
      READ_D = io_regs_q[io_idx];
    end
  end

  // Preload is written after the core write so it wins on an address clash.
  always_ff @(posedge CLK) begin
    if (start_mwr) begin
      mem[A[MEM_AW-1:0]] <= WRITE_D;
    end
    if (load_we) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      mrd_q      <= 1'b0;
      mwr_q      <= 1'b0;
      io_q       <= 1'b0;
      ev_valid_q <= 1'b0;
      ev_kind_q  <= ACC_FETCH;
      ev_addr_q  <= '0;
      ev_data_q  <= '0;
      for (int i = 0; i < IO_PORTS; i++) begin
        io_regs_q[i] <= '0;
      end
    end else begin
      mrd_q      <= mrd_act;
      mwr_q      <= mwr_act;
      io_q       <= io_act;
      ev_valid_q <= start_any;
      if (start_any) begin
        ev_kind_q <= acc_kind;
        ev_addr_q <= A;
        ev_data_q <= acc_is_wr ? WRITE_D : READ_D;
      end
      if (start_io && !nWR) begin
        io_regs_q[io_idx] <= WRITE_D;
      end
    end
  end

  assign ev_valid = ev_valid_q;
  assign ev_kind  = ev_kind_q;
  assign ev_addr  = ev_addr_q;
  assign ev_data  = ev_data_q;

  z80_wait_gen #(
    .WAIT_M1  (WAIT_M1),
    .WAIT_MEM (WAIT_MEM),
    .WAIT_IO  (WAIT_IO)
  ) u_wait_gen (
    .clk_i    (CLK),
    .rst_n_i  (nRESET),
    .start_i  (start_any),
    .kind_i   (acc_kind),
    .active_i (any_act),
    .nwait_o  (nWAIT)
  );

  // Bus-request cycle: count a period, request, hold the granted bus for
  // BUSRQ_HOLD cycles, then wait for the core to take the bus back.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      br_state_q <= BR_IDLE;
      br_cnt_q   <= '0;
      nbusrq_q   <= 1'b1;
    end else begin
      case (br_state_q)
        BR_IDLE: begin
          if (BUSRQ_PERIOD != 0) begin
            if (br_cnt_q == 16'(BUSRQ_PERIOD - 1)) begin
              br_state_q <= BR_REQ;
              br_cnt_q   <= '0;
              nbusrq_q   <= 1'b0;
            end else begin
              br_cnt_q <= br_cnt_q + 16'd1;
            end
          end
        end
        BR_REQ: begin
          if (!nBUSAK) begin
            br_state_q <= BR_GRANT;
            br_cnt_q   <= '0;
          end
        end
        BR_GRANT: begin
          if (int'(br_cnt_q) + 1 >= BUSRQ_HOLD) begin
            br_state_q <= BR_RELEASE;
            br_cnt_q   <= '0;
            nbusrq_q   <= 1'b1;
          end else begin
            br_cnt_q <= br_cnt_q + 16'd1;
          end
        end
        BR_RELEASE: begin
          if (nBUSAK) begin
            br_state_q <= BR_IDLE;
            br_cnt_q   <= '0;
          end
        end
        default: begin
          br_state_q <= BR_IDLE;
          br_cnt_q   <= '0;
          nbusrq_q   <= 1'b1;
        end
      endcase
    end
  end

  assign nBUSRQ = nbusrq_q;

endmodule

// File: tb/tb_z80_bus_model.sv
// tb/tb_z80_bus_model.sv - self-checking bench for z80_bus_model
module tb_z80_bus_model;

  localparam int WM1   = 1;
  localparam int WMEM  = 2;
  localparam int WIO   = 3;
  localparam int NPORT = 4;
  localparam int PER   = 10;
  localparam int HOLD  = 4;

  logic        CLK = 1'b0;
  logic        nRESET;
  logic [15:0] A;
  logic        nMREQ, nIORQ, nRD, nWR, nM1, nRFSH;
  logic        busak_a, nBUSAK_b;
  logic [7:0]  WRITE_D;
  logic        load_we;
  logic [15:0] load_addr;
  logic [7:0]  load_data;

  logic [7:0]  rd_a, rd_b, evd_a, evd_b;
  logic        nwait_a, nwait_b, nbusrq_a, nbusrq_b, evv_a, evv_b;
  logic [1:0]  evk_a, evk_b;
  logic [15:0] eva_a, eva_b;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference state: what memory and the I/O ports must hold.
  logic [7:0]  mem_m [logic [15:0]];
  logic [7:0]  io_m [NPORT];
  logic [15:0] pool [16];

  always #5 CLK = ~CLK;

  z80_bus_model #(
    .MEM_AW(16), .IO_PORTS(NPORT), .WAIT_M1(WM1), .WAIT_MEM(WMEM), .WAIT_IO(WIO),
    .BUSRQ_PERIOD(0), .BUSRQ_HOLD(HOLD)
  ) dut_a (
    .CLK(CLK), .nRESET(nRESET), .A(A), .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD),
    .nWR(nWR), .nM1(nM1), .nRFSH(nRFSH), .nBUSAK(busak_a), .WRITE_D(WRITE_D),
    .READ_D(rd_a), .nWAIT(nwait_a), .nBUSRQ(nbusrq_a), .load_we(load_we),
    .load_addr(load_addr), .load_data(load_data), .ev_valid(evv_a), .ev_kind(evk_a),
    .ev_addr(eva_a), .ev_data(evd_a)
  );

  z80_bus_model #(
    .MEM_AW(16), .IO_PORTS(NPORT), .WAIT_M1(0), .WAIT_MEM(0), .WAIT_IO(0),
    .BUSRQ_PERIOD(PER), .BUSRQ_HOLD(HOLD)
  ) dut_b (
    .CLK(CLK), .nRESET(nRESET), .A(A), .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD),
    .nWR(nWR), .nM1(nM1), .nRFSH(nRFSH), .nBUSAK(nBUSAK_b), .WRITE_D(WRITE_D),
    .READ_D(rd_b), .nWAIT(nwait_b), .nBUSRQ(nbusrq_b), .load_we(load_we),
    .load_addr(load_addr), .load_data(load_data), .ev_valid(evv_b), .ev_kind(evk_b),
    .ev_addr(eva_b), .ev_data(evd_b)
  );

  // Access kinds used by the bench: 0 fetch, 1 mem read, 2 mem write, 3 io read, 4 io write
  function automatic int exp_wait(input int k);
    if (k == 0) return WM1;
    if (k <= 2) return WMEM;
    return WIO;
  endfunction

  task automatic strobes_idle();
    nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nM1 = 1'b1; nRFSH = 1'b1;
  endtask

  task automatic strobes_for(input int k);
    nM1   = (k == 0) ? 1'b0 : 1'b1;
    nMREQ = (k <= 2) ? 1'b0 : 1'b1;
    nIORQ = (k >= 3) ? 1'b0 : 1'b1;
    nRD   = (k == 0 || k == 1 || k == 3) ? 1'b0 : 1'b1;
    nWR   = (k == 2 || k == 4) ? 1'b0 : 1'b1;
    nRFSH = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    strobes_idle();
    nBUSAK_b = 1'b1;
    load_we = 1'b0;
    nRESET = 1'b0;
    repeat (2) @(negedge CLK);
    nRESET = 1'b1;
    for (int i = 0; i < NPORT; i++) io_m[i] = 8'h00;
  endtask

  task automatic load_byte(input logic [15:0] addr, input logic [7:0] data);
    @(negedge CLK);
    load_we = 1'b1; load_addr = addr; load_data = data;
    @(negedge CLK);
    load_we = 1'b0;
    mem_m[addr] = data;
  endtask

  // One complete core bus cycle on dut_a, with an optional preload on the start edge.
  task automatic do_access(input int k, input logic [15:0] addr, input logic [7:0] wd,
                           input int extra, input logic ld, input logic [15:0] la,
                           input logic [7:0] ldv);
    logic [7:0] exp_d;
    logic [1:0] exp_k;
    logic       ev_ok;
    int pidx, w, n, nlow, nev, zlow;
    pidx  = int'(addr[7:0]) % NPORT;
    w     = exp_wait(k);
    exp_k = (k >= 3) ? 2'd3 : 2'(k);
    if (k == 2 || k == 4) exp_d = wd;
    else if (k == 3)      exp_d = io_m[pidx];
    else                  exp_d = mem_m[addr];
    @(negedge CLK);
    A = addr; WRITE_D = wd;
    load_we = ld; load_addr = la; load_data = ldv;
    strobes_for(k);
    #1;
    if (k == 0 || k == 1 || k == 3) begin
      tests_run++;
      if (rd_a !== exp_d) begin
        tests_failed++;
        $display("FAIL read_data k=%0d a=%h: got %h expected %h", k, addr, rd_a, exp_d);
      end
    end
    if (k == 2) mem_m[addr] = wd;
    if (k == 4) io_m[pidx] = wd;
    if (ld) mem_m[la] = ldv;
    n = w + 1 + extra; nlow = 0; nev = 0; zlow = 0; ev_ok = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (c == 0) begin
        load_we = 1'b0;
        WRITE_D = ~wd;
        ev_ok = (evv_a === 1'b1) && (evk_a === exp_k) && (eva_a === addr) && (evd_a === exp_d);
        tests_run++;
        if (!ev_ok) begin
          tests_failed++;
          $display("FAIL ev_fields: got v=%b k=%0d a=%h d=%h expected v=1 k=%0d a=%h d=%h",
                   evv_a, evk_a, eva_a, evd_a, exp_k, addr, exp_d);
        end
      end
      if (nwait_a === 1'b0) nlow++;
      if (evv_a === 1'b1) nev++;
      if (nwait_b === 1'b0) zlow++;
    end
    tests_run++;
    if (nlow != w) begin
      tests_failed++;
      $display("FAIL wait_cycles k=%0d: got %0d expected %0d", k, nlow, w);
    end
    tests_run++;
    if (nev != 1) begin
      tests_failed++;
      $display("FAIL ev_pulse_count k=%0d: got %0d expected 1", k, nev);
    end
    tests_run++;
    if (zlow != 0) begin
      tests_failed++;
      $display("FAIL zero_wait_low: got %0d expected 0", zlow);
    end
    strobes_idle();
    #1;
    tests_run++;
    if (rd_a !== 8'hFF) begin
      tests_failed++;
      $display("FAIL idle_read_d: got %h expected ff", rd_a);
    end
  endtask

  task automatic test_reset();
    nRESET = 1'b0; busak_a = 1'b1; nBUSAK_b = 1'b1;
    A = '0; WRITE_D = '0; load_we = 1'b0; load_addr = '0; load_data = '0;
    strobes_idle();
    apply_reset();
    #1;
    tests_run++;
    if ({rd_a, nwait_a, nbusrq_a, nbusrq_b, evv_a} !== {8'hFF, 1'b1, 1'b1, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_outputs: got rd=%h w=%b br=%b brb=%b ev=%b expected ff 1 1 1 0",
               rd_a, nwait_a, nbusrq_a, nbusrq_b, evv_a);
    end
    tests_run++;
    if ({evk_a, eva_a, evd_a} !== 26'd0) begin
      tests_failed++;
      $display("FAIL reset_ev_fields: got k=%0d a=%h d=%h expected 0", evk_a, eva_a, evd_a);
    end
  endtask

  task automatic test_preload_fetch();
    load_byte(16'h0000, 8'h3E);
    load_byte(16'h0001, 8'h55);
    do_access(0, 16'h0000, 8'h00, 0, 1'b0, 16'h0, 8'h0);
    do_access(1, 16'h0001, 8'h00, 0, 1'b0, 16'h0, 8'h0);
  endtask

  task automatic test_write_once();
    do_access(2, 16'h8000, 8'hA5, 1, 1'b0, 16'h0, 8'h0);
    do_access(1, 16'h8000, 8'h00, 0, 1'b0, 16'h0, 8'h0);
  endtask

  task automatic test_io();
    do_access(4, 16'h0004, 8'h77, 0, 1'b0, 16'h0, 8'h0);
    do_access(3, 16'h0010, 8'h00, 0, 1'b0, 16'h0, 8'h0);
    do_access(4, 16'h0005, 8'h3C, 0, 1'b0, 16'h0, 8'h0);
    do_access(3, 16'h0001, 8'h00, 0, 1'b0, 16'h0, 8'h0);
    do_access(4, 16'h1207, 8'hC9, 0, 1'b0, 16'h0, 8'h0);
    do_access(3, 16'hAB03, 8'h00, 0, 1'b0, 16'h0, 8'h0);
  endtask

  task automatic test_load_collision();
    do_access(2, 16'h4000, 8'h11, 0, 1'b1, 16'h4000, 8'h22);
    do_access(1, 16'h4000, 8'h00, 0, 1'b0, 16'h0, 8'h0);
    do_access(2, 16'h4001, 8'h33, 0, 1'b1, 16'h4002, 8'h44);
    do_access(1, 16'h4001, 8'h00, 0, 1'b0, 16'h0, 8'h0);
    do_access(1, 16'h4002, 8'h00, 0, 1'b0, 16'h0, 8'h0);
  endtask

  task automatic test_wait_early_release();
    @(negedge CLK);
    A = pool[0];
    strobes_for(1);
    @(posedge CLK);
    @(negedge CLK);
    tests_run++;
    if (nwait_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL early_wait_start: got %b expected 0", nwait_a);
    end
    strobes_idle();
    @(posedge CLK);
    @(negedge CLK);
    tests_run++;
    if (nwait_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL early_release_nwait: got %b expected 1", nwait_a);
    end
  endtask

  task automatic test_refresh();
    int nev, nlow;
    nev = 0; nlow = 0;
    @(negedge CLK);
    A = 16'h1234; nMREQ = 1'b0; nRFSH = 1'b0;
    repeat (3) begin
      @(posedge CLK);
      @(negedge CLK);
      if (evv_a === 1'b1) nev++;
      if (nwait_a === 1'b0) nlow++;
    end
    strobes_idle();
    tests_run++;
    if (nev != 0 || nlow != 0) begin
      tests_failed++;
      $display("FAIL refresh_quiet: got ev=%0d waitlow=%0d expected 0 0", nev, nlow);
    end
  endtask

  task automatic test_random();
    int k;
    logic [15:0] addr;
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 4);
      addr = (k <= 2) ? pool[$urandom_range(0, 15)] : 16'($urandom);
      do_access(k, addr, 8'($urandom), $urandom_range(0, 2), 1'b0, 16'h0, 8'h0);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] p;
    p = pool[3];
    @(negedge CLK);
    A = p;
    strobes_for(1);
    @(posedge CLK);
    @(negedge CLK);
    tests_run++;
    if (nwait_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_wait_active: got %b expected 0", nwait_a);
    end
    nRESET = 1'b0;
    #1;
    tests_run++;
    if ({nwait_a, rd_a, evv_a, nbusrq_b} !== {1'b1, 8'hFF, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs: got w=%b rd=%h ev=%b brb=%b expected 1 ff 0 1",
               nwait_a, rd_a, evv_a, nbusrq_b);
    end
    // A write presented while reset is held must not reach memory.
    @(negedge CLK);
    WRITE_D = ~mem_m[p];
    strobes_for(2);
    @(negedge CLK);
    strobes_idle();
    @(negedge CLK);
    nRESET = 1'b1;
    for (int i = 0; i < NPORT; i++) io_m[i] = 8'h00;
    do_access(1, p, 8'h00, 0, 1'b0, 16'h0, 8'h0);
    do_access(3, 16'h0002, 8'h00, 0, 1'b0, 16'h0, 8'h0);
  endtask

  task automatic test_busrq();
    int n, nl, nev, bad;
    apply_reset();
    n = 0;
    do begin
      @(posedge CLK);
      @(negedge CLK);
      n++;
    end while (nbusrq_b !== 1'b0 && n < 100);
    tests_run++;
    if (n != PER) begin
      tests_failed++;
      $display("FAIL busrq_first_request: got %0d cycles expected %0d", n, PER);
    end
    repeat ($urandom_range(1, 3)) @(negedge CLK);
    tests_run++;
    if (nbusrq_b !== 1'b0) begin
      tests_failed++;
      $display("FAIL busrq_held_until_ack: got %b expected 0", nbusrq_b);
    end
    nBUSAK_b = 1'b0;
    A = pool[5];
    strobes_for(1);
    nl = 0; nev = 0; bad = 0;
    do begin
      @(posedge CLK);
      @(negedge CLK);
      if (nbusrq_b === 1'b0) nl++;
      if (evv_b === 1'b1) nev++;
      if (nwait_b !== 1'b1 || rd_b !== 8'hFF) bad++;
    end while (nbusrq_b === 1'b0 && nl < 50);
    strobes_idle();
    tests_run++;
    if (nl != HOLD) begin
      tests_failed++;
      $display("FAIL busrq_hold: got %0d cycles expected %0d", nl, HOLD);
    end
    tests_run++;
    if (nev != 0 || bad != 0) begin
      tests_failed++;
      $display("FAIL grant_quiet: got ev=%0d bus_driven=%0d expected 0 0", nev, bad);
    end
    nBUSAK_b = 1'b1;
    // The edge that sees nBUSAK high returns to idle; a full period follows it.
    n = 0;
    do begin
      @(posedge CLK);
      @(negedge CLK);
      n++;
    end while (nbusrq_b !== 1'b0 && n < 100);
    tests_run++;
    if (n != PER + 1) begin
      tests_failed++;
      $display("FAIL busrq_second_request: got %0d cycles expected %0d", n, PER + 1);
    end
    nBUSAK_b = 1'b0;
    repeat (2) @(negedge CLK);
    nRESET = 1'b0;
    #1;
    tests_run++;
    if (nbusrq_b !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_grant: got %b expected 1", nbusrq_b);
    end
    nBUSAK_b = 1'b1;
    @(negedge CLK);
    nRESET = 1'b1;
    for (int i = 0; i < NPORT; i++) io_m[i] = 8'h00;
    do_access(1, 16'h8000, 8'h00, 0, 1'b0, 16'h0, 8'h0);
  endtask

  initial begin
    test_reset();
    test_preload_fetch();
    for (int i = 0; i < 16; i++) begin
      pool[i] = 16'($urandom);
      load_byte(pool[i], 8'($urandom));
    end
    test_write_once();
    test_io();
    test_load_collision();
    test_wait_early_release();
    test_refresh();
    test_random();
    test_reset_mid();
    test_busrq();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
